// File: rtl/ctrl_layer_fsm.sv
// ============================================================================
// ctrl_layer_fsm : layer-sequencing FSM, one accumulate window + write per volume
// Revision 1.0
// ============================================================================
`default_nettype none

module ctrl_layer_fsm #(
  parameter  int MNV = 224*224,
  parameter  int MVL = 1024,
  localparam int VW  = $clog2(MNV),
  localparam int LW  = $clog2(MVL+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [VW-1:0] num_vol,
  input  logic [LW-1:0] vol_len,
  input  logic          op_done,
  input  logic          out_ready,
  output logic          cnt_clear_vol,
  output logic          cnt_load,
  output logic          cnt_in_vol,
  output logic [VW-1:0] max_val,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          out_valid,
  output logic          busy,
  output logic          layer_done,
  output logic [VW-1:0] vol_idx
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cyc_q, cyc_d;
  logic [VW-1:0] max_val_q, max_val_d;
  logic [VW-1:0] vol_idx_q, vol_idx_d;
  logic          last_q, last_d;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cyc_d     = cyc_q;
    max_val_d = max_val_q;
    vol_idx_d = vol_idx_q;
    last_d    = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLEAR;
          max_val_d = (num_vol == '0) ? VW'(1) : num_vol;
          len_d     = (vol_len == '0) ? LW'(1) : vol_len;
          vol_idx_d = '0;
          last_d    = 1'b0;
        end
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_COMPUTE;
        cyc_d   = '0;
      end
      S_COMPUTE: begin
        cyc_d = cyc_q + LW'(1);
        if (cyc_q == len_q - LW'(1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        // The counter wraps on cnt_in_vol, so op_done is only trustworthy here.
        if (out_ready) begin
          last_d  = op_done;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        vol_idx_d = vol_idx_q + VW'(1);
        cyc_d     = '0;
        state_d   = last_q ? S_IDLE : S_COMPUTE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cyc_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= LW'(1);
      cyc_q     <= '0;
      max_val_q <= '0;
      vol_idx_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cyc_q     <= cyc_d;
      max_val_q <= max_val_d;
      vol_idx_q <= vol_idx_d;
      last_q    <= last_d;
    end
  end

  // Abort clears the volume counter on the same edge the FSM returns to IDLE,
  // which is the one place an input reaches an output without a register.
  assign cnt_clear_vol = (state_q == S_CLEAR) || (abort && state_q != S_IDLE);
  assign cnt_load      = (state_q == S_LOAD);
  assign cnt_in_vol    = (state_q == S_FINISH);
  assign acc_en        = (state_q == S_COMPUTE);
  assign acc_clr       = (state_q == S_COMPUTE) && (cyc_q == '0);
  assign out_valid     = (state_q == S_WRITE);
  assign busy          = (state_q != S_IDLE);
  assign layer_done    = (state_q == S_FINISH) && last_q;
  assign max_val       = max_val_q;
  assign vol_idx       = vol_idx_q;

endmodule

`default_nettype wire
